op_skid_stage: RTL and testbench

Two-entry skid-buffered pipeline register for the EX-stage operand path. It captures a pair of 32-bit operand candidates plus their forwarding select from the ID stage, then presents them to the downstream 2:1 operand mux. It supports full throughput with valid/ready backpressure, and a synchronous flush for branch redirect. Its registered outputs drive the operand mux's `in0`, `in1` and `select` pins directly.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/op_skid_stage_payload_reg.sv | 21 ++
 rtl/op_skid_stage.sv | 127 ++++++++++++
 tb/tb_op_skid_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the EX-stage operand skid stage: state encoding and payload layout.
// Used by op_skid_stage (optional stall counter under OP_SKID_STALL_CNT_EN).
package pipe_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] in0;
        logic [DATA_W-1:0] in1;
        logic              sel;
    } op_payload_t;

endpackage

// File: rtl/op_skid_stage_payload_reg.sv
// Generic load-enabled payload register with asynchronous active-high reset.
// Holds one skid-stage entry (main or skid).
module payload_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/op_skid_stage.sv
// Two-entry skid-buffered operand register feeding the EX operand mux.
// Optional stall cycle counter on port stall_cnt when OP_SKID_STALL_CNT_EN is defined.
module op_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0_d,
    input  logic [WIDTH-1:0] in1_d,
    input  logic             sel_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] in0_q,
    output logic [WIDTH-1:0] in1_q,
    output logic             sel_q
`ifdef OP_SKID_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    localparam int PW = 2 * WIDTH + 1;

    skid_state_t   state;
    skid_state_t   state_next;
    logic          in_fire;
    logic          out_fire;
    logic          load_main;
    logic          load_skid;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;

    assign in_ready   = (state != FULL);
    assign out_valid  = (state != EMPTY);
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign in_payload = {in0_d, in1_d, sel_d};

    // When draining from FULL the main entry refills from the skid entry, otherwise from the input.
    assign main_d = (state == FULL) ? skid_q : in_payload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = ONE;
                        load_main  = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_next = ONE;
                        load_main  = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    payload_reg #(.WIDTH(PW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (load_main),
        .d    (main_d),
        .q    (main_q)
    );

    payload_reg #(.WIDTH(PW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (load_skid),
        .d    (in_payload),
        .q    (skid_q)
    );

    assign {in0_q, in1_q, sel_q} = main_q;

`ifdef OP_SKID_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles where a payload is presented but not taken; flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_op_skid_stage.sv
// Scoreboard bench for op_skid_stage: directed payloads, monitor checks order and hold stability.
// Stall counter checks compile in only when OP_SKID_STALL_CNT_EN is defined.
module tb_op_skid_stage;
    import pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in0_d;
    logic [31:0] in1_d;
    logic        sel_d;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in0_q;
    logic [31:0] in1_q;
    logic        sel_q;
`ifdef OP_SKID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    op_payload_t exp_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    op_skid_stage #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0_d     (in0_d),
        .in1_d     (in1_d),
        .sel_d     (sel_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in0_q     (in0_q),
        .in1_q     (in1_q),
        .sel_q     (sel_q)
`ifdef OP_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] expv);
        total_cnt++;
        if (act === expv) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                  input logic s, input logic push);
        op_payload_t p;
        in_valid = v;
        in0_d    = a;
        in1_d    = b;
        sel_d    = s;
        if (push) begin
            p.in0 = a;
            p.in1 = b;
            p.sel = s;
            exp_q.push_back(p);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: delivered payloads must match the queue head; held payloads must not change.
    always @(negedge clk) begin
        op_payload_t got;
        if (!rst && out_valid) begin
            got = {in0_q, in1_q, sel_q};
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL unexpected_out: got %0h expected no payload", got);
            end else if (out_ready) begin
                check_output("deliver", 96'(got), 96'(exp_q[0]));
                void'(exp_q.pop_front());
            end else begin
                check_output("hold", 96'(got), 96'(exp_q[0]));
            end
        end
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        apply_stimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        #12;
        check_output("rst_in_ready", 96'(in_ready), 96'd1);
        check_output("rst_out_valid", 96'(out_valid), 96'd0);
        check_output("rst_payload", 96'({in0_q, in1_q, sel_q}), 96'd0);
`ifdef OP_SKID_STALL_CNT_EN
        check_output("rst_stall_cnt", 96'(stall_cnt), 96'd0);
`endif
        rst = 1'b0;
        step(2);
        check_output("idle_out_valid", 96'(out_valid), 96'd0);

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, 32'(i), 32'h100 + 32'(i), i[0], 1'b1);
            check_output("stream_in_ready", 96'(in_ready), 96'd1);
            step(1);
            check_output("stream_out_valid", 96'(out_valid), 96'd1);
        end
        apply_stimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(2);
        check_output("stream_drained", 96'(exp_q.size()), 96'd0);
        check_output("stream_empty", 96'(out_valid), 96'd0);

        // Backpressure: A held, B skidded, C refused until drain
        out_ready = 1'b0;
        apply_stimulus(1'b1, 32'hA0, 32'hA1, 1'b1, 1'b1);
        step(1);
`ifdef OP_SKID_STALL_CNT_EN
        check_output("bp_stall_0", 96'(stall_cnt), 96'd0);
`endif
        apply_stimulus(1'b1, 32'hB0, 32'hB1, 1'b0, 1'b1);
        check_output("bp_ready_b", 96'(in_ready), 96'd1);
        step(1);
`ifdef OP_SKID_STALL_CNT_EN
        check_output("bp_stall_1", 96'(stall_cnt), 96'd1);
`endif
        apply_stimulus(1'b1, 32'hC0, 32'hC1, 1'b1, 1'b0);
        check_output("bp_ready_c", 96'(in_ready), 96'd0);
        step(1);
`ifdef OP_SKID_STALL_CNT_EN
        check_output("bp_stall_2", 96'(stall_cnt), 96'd2);
`endif
        check_output("bp_full_ready", 96'(in_ready), 96'd0);
        step(1);
`ifdef OP_SKID_STALL_CNT_EN
        check_output("bp_stall_3", 96'(stall_cnt), 96'd3);
`endif
        out_ready = 1'b1;
        apply_stimulus(1'b1, 32'hC0, 32'hC1, 1'b1, 1'b1);
        step(1);
        check_output("drain_ready", 96'(in_ready), 96'd1);
        check_output("drain_in0_b", 96'(in0_q), 96'hB0);
        step(1);
        apply_stimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1);
        check_output("drain_done", 96'(exp_q.size()), 96'd0);
        check_output("drain_empty", 96'(out_valid), 96'd0);

        // Flush while FULL drops both entries and the offered payload
        out_ready = 1'b0;
        apply_stimulus(1'b1, 32'hD0, 32'hD1, 1'b0, 1'b1);
        step(1);
        apply_stimulus(1'b1, 32'hE0, 32'hE1, 1'b1, 1'b1);
        step(1);
        check_output("pre_flush_ready", 96'(in_ready), 96'd0);
        flush = 1'b1;
        apply_stimulus(1'b1, 32'hF0, 32'hF1, 1'b1, 1'b0);
        step(1);
        exp_q.delete();
        flush = 1'b0;
        apply_stimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check_output("flush_out_valid", 96'(out_valid), 96'd0);
        check_output("flush_in_ready", 96'(in_ready), 96'd1);
`ifdef OP_SKID_STALL_CNT_EN
        check_output("flush_stall_kept", 96'(stall_cnt), 96'd5);
`endif
        out_ready = 1'b1;
        step(3);
        check_output("flush_still_empty", 96'(out_valid), 96'd0);

        // Asynchronous reset between edges while FULL
        out_ready = 1'b0;
        apply_stimulus(1'b1, 32'h60, 32'h61, 1'b1, 1'b1);
        step(1);
        apply_stimulus(1'b1, 32'h70, 32'h71, 1'b0, 1'b1);
        step(1);
        apply_stimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_output("arst_out_valid", 96'(out_valid), 96'd0);
        check_output("arst_in_ready", 96'(in_ready), 96'd1);
        check_output("arst_payload", 96'({in0_q, in1_q, sel_q}), 96'd0);
`ifdef OP_SKID_STALL_CNT_EN
        check_output("arst_stall_cnt", 96'(stall_cnt), 96'd0);
`endif
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        step(3);
        check_output("arst_no_stale", 96'(out_valid), 96'd0);

`ifdef OP_SKID_STALL_CNT_EN
        // Saturation from just below the ceiling
        out_ready = 1'b0;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        apply_stimulus(1'b1, 32'h90, 32'h91, 1'b1, 1'b1);
        step(1);
        check_output("sat_pre", 96'(stall_cnt), 96'hFFFF_FFFE);
        apply_stimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(3);
        check_output("sat_hold", 96'(stall_cnt), 96'hFFFF_FFFF);
        out_ready = 1'b1;
        step(2);
`endif

        check_output("final_queue", 96'(exp_q.size()), 96'd0);
        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
